// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with a registered carry.
// Define SEQ_ADDSUB_SAT_EN to saturate the result to signed limits on overflow.
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE, CALC} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_sub;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK-1:0] w_a_c;
  logic [CHUNK-1:0] w_bx;
  logic [CHUNK:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_final;
  logic [WIDTH-1:0] w_res;

  // Subtract is a + ~b + 1: the +1 comes from preloading the carry with sub.
  assign w_a_c = r_a[CHUNK*int'(r_cnt) +: CHUNK];
  assign w_bx  = r_b[CHUNK*int'(r_cnt) +: CHUNK] ^ {CHUNK{r_sub}};
  assign w_sum = {1'b0, w_a_c} + {1'b0, w_bx} + {{CHUNK{1'b0}}, r_carry};
  // Same-sign operands producing an opposite-sign MSB; only meaningful on the last chunk.
  assign w_ovf = (w_a_c[CHUNK-1] ~^ w_bx[CHUNK-1]) & (w_sum[CHUNK-1] ^ w_a_c[CHUNK-1]);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_final = r_acc;
    w_final[CHUNK*int'(r_cnt) +: CHUNK] = w_sum[CHUNK-1:0];
    w_res = w_final;
`ifdef SEQ_ADDSUB_SAT_EN
    if (w_ovf) begin
      w_res = w_a_c[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= sub;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc   <= w_final;
          r_carry <= w_sum[CHUNK];
          if (r_cnt == LAST) begin
            result   <= w_res;
            c_out    <= w_sum[CHUNK];
            overflow <= w_ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed-vector bench for seq_addsub: default 32/4 instance plus a 16/8 instance.
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, c_out, overflow;
  logic [31:0] result;

  logic        start16 = 1'b0;
  logic        sub16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16, done16, c_out16, overflow16;
  logic [15:0] result16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(8)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .c_out(c_out16), .overflow(overflow16)
  );

  // Pulse start for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tsub);
    @(negedge clk);
    a = ta; b = tb; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done, bounded; also records whether busy stayed high meanwhile.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
    end
    vectors++;
    if (result !== 32'h0 || c_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_data: result=%h c_out=%b ovf=%b, want 0 0 0", result, c_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sub;
    int cyc;
    bit busy_ok;
    start_op(32'h5, 32'h3, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_busy_rise: busy=%b, want 1", busy);
    end
    wait_done(cyc, busy_ok);
    vectors++;
    if (cyc !== 8 || !busy_ok) begin
      miscompares++;
      $display("FAIL sub_latency: cycles=%0d busy_ok=%b, want 8 1", cyc, busy_ok);
    end
    vectors++;
    if (result !== 32'h2 || c_out !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_5_3: result=%h c=%b v=%b busy=%b, want 00000002 1 0 0",
               result, c_out, overflow, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || result !== 32'h2) begin
      miscompares++;
      $display("FAIL done_pulse_hold: done=%b result=%h, want 0 00000002", done, result);
    end
  endtask

  task automatic test_borrow;
    int cyc;
    bit busy_ok;
    start_op(32'h3, 32'h5, 1'b1);
    wait_done(cyc, busy_ok);
    vectors++;
    if (cyc !== 8 || result !== 32'hFFFF_FFFE || c_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_3_5: cyc=%0d result=%h c=%b v=%b, want 8 fffffffe 0 0",
               cyc, result, c_out, overflow);
    end
  endtask

  task automatic test_carry_overflow;
    int cyc;
    bit busy_ok;
    logic [31:0] exp_sat;
    start_op(32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_done(cyc, busy_ok);
    vectors++;
    if (result !== 32'h0 || c_out !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL add_carry: result=%h c=%b v=%b, want 00000000 1 0", result, c_out, overflow);
    end
`ifdef SEQ_ADDSUB_SAT_EN
    exp_sat = 32'h7FFF_FFFF;
`else
    exp_sat = 32'h8000_0000;
`endif
    start_op(32'h7FFF_FFFF, 32'h1, 1'b0);
    wait_done(cyc, busy_ok);
    vectors++;
    if (result !== exp_sat || c_out !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL add_overflow: result=%h c=%b v=%b, want %h 0 1", result, c_out, overflow, exp_sat);
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    bit stable;
    logic [31:0] prev;
    prev = result;
    stable = 1'b1;
    cyc = 0;
    start_op(32'h0000_0010, 32'h0000_0001, 1'b0);
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cyc == 3) begin
        start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (!done && result !== prev) stable = 1'b0;
    end
    vectors++;
    if (cyc !== 8 || result !== 32'h11 || c_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start: cyc=%0d result=%h c=%b v=%b, want 8 00000011 0 0",
               cyc, result, c_out, overflow);
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL result_stable: result moved during CALC, want held at %h", prev);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_not_queued: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit busy_ok;
    @(negedge clk);
    a = 32'h0000_1000; b = 32'h0000_0234; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h0000_0100; b = 32'h0000_0200; sub = 1'b1;
    wait_done(cyc, busy_ok);
    vectors++;
    if (cyc !== 8 || result !== 32'h0000_1234 || c_out !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first: cyc=%0d result=%h c=%b, want 8 00001234 0", cyc, result, c_out);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(cyc, busy_ok);
    vectors++;
    if (cyc !== 8 || !busy_ok || result !== 32'hFFFF_FF00 || c_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: cyc=%0d busy_ok=%b result=%h c=%b v=%b, want 8 1 ffffff00 0 0",
               cyc, busy_ok, result, c_out, overflow);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit busy_ok;
    bit seen_done;
    start_op(32'h0000_0009, 32'h0000_0004, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || c_out !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h c=%b v=%b, want all 0",
               busy, done, result, c_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done) begin
      miscompares++;
      $display("FAIL reset_no_done: activity after reset without start, want none");
    end
    start_op(32'h0000_0009, 32'h0000_0004, 1'b1);
    wait_done(cyc, busy_ok);
    vectors++;
    if (cyc !== 8 || result !== 32'h5 || c_out !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_recover: cyc=%0d result=%h c=%b v=%b, want 8 00000005 1 0",
               cyc, result, c_out, overflow);
    end
  endtask

  task automatic test_w16;
    int cyc;
    logic [15:0] exp16;
`ifdef SEQ_ADDSUB_SAT_EN
    exp16 = 16'h8000;
`else
    exp16 = 16'h7FFF;
`endif
    @(negedge clk);
    a16 = 16'h8000; b16 = 16'h0001; sub16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done16) break;
    end
    vectors++;
    if (cyc !== 2 || result16 !== exp16 || c_out16 !== 1'b1 || overflow16 !== 1'b1) begin
      miscompares++;
      $display("FAIL w16_sub: cyc=%0d result=%h c=%b v=%b, want 2 %h 1 1",
               cyc, result16, c_out16, overflow16, exp16);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_sub();
    test_borrow();
    test_carry_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor for the UART hex calculator datapath.
- Successor to the fixed 32-bit, 4-bit-chunk ripple subtractor: width and chunk size are parameters, and add or subtract is selected per operation.
- Processes one CHUNK-bit slice per clock with a registered carry, trading latency for a short critical path.
- Uses a start/busy/done handshake toward the calculator FSM.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per clock cycle; must be at least 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; accepted only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result, c_out and overflow are valid from this cycle.
- result  output  WIDTH  sum or difference.
- c_out  output  1  carry out; for subtract, 1 = no borrow (a >= b unsigned).
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: busy=0, done=0, result=0, c_out=0, overflow=0; FSM returns to IDLE.
- Derived constant: N = WIDTH/CHUNK.
- Elaboration check: WIDTH not a multiple of CHUNK, or CHUNK < 1, must fail elaboration (generate-time error).
- FSM states: IDLE, CALC.
- IDLE:
  - On start=1 at edge k, latch a, b, sub.
  - Preload the internal carry with sub.
  - Clear the chunk counter.
  - Go to CALC; busy=1 from edge k.
- CALC:
  - Edge k+1+i computes chunk i (bits [CHUNK*i +: CHUNK]) as a_chunk + (b_chunk XOR {CHUNK{sub}}) + carry.
  - Store the chunk into the internal shift/accumulate register; register the carry.
- Completion at edge k+N:
  - Load result, c_out (final carry) and overflow (carry into MSB XOR carry out of MSB).
  - Assert done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: N cycles from the start edge to done (8 for the defaults).
- Result stability:
  - result/c_out/overflow are not updated during CALC; the previous result stays visible until the next completion.
  - They hold indefinitely after done.
- start while busy=1 is ignored; operands are not re-latched and the operation is not queued.
- start in the same cycle as done=1 is accepted (busy already 0); back-to-back throughput is one operation per N cycles.
- Input changes on a/b/sub while busy have no effect.
- Reset asserted mid-CALC:
  - Abort immediately; no done pulse.
  - Outputs go to reset values.
  - After release, a new start is required.
- CHUNK=WIDTH is legal: N=1, single-cycle latency, done one cycle after start.
- Wrap-around: result is modulo 2^WIDTH; c_out/overflow report the out-of-range condition.

Optional Feature:
- Macro: SEQ_ADDSUB_SAT_EN.
- Defined: when overflow=1, result saturates to signed limits.
  - Positive overflow gives 0111..1; negative overflow gives 1000..0.
  - overflow flag and c_out are still reported unchanged.
  - Saturation is applied at the completion edge; latency is unchanged.
- Undefined: result is the wrapped modulo-2^WIDTH value; no saturation logic is synthesised.

Test Plan:
- Defaults, sub=1, a=0x00000005, b=0x00000003, start one cycle -> busy high 8 cycles; done pulses 8 cycles after start; result=0x00000002, c_out=1, overflow=0.
- Borrow case, sub=1, a=0x00000003, b=0x00000005 -> result=0xFFFFFFFE, c_out=0, overflow=0.
- Carry/overflow pair:
  - Add 0xFFFFFFFF+0x00000001 -> result=0, c_out=1, overflow=0.
  - Add 0x7FFFFFFF+0x00000001 -> overflow=1; result=0x80000000 without macro, 0x7FFFFFFF with SEQ_ADDSUB_SAT_EN.
- Handshake:
  - Second start pulsed 3 cycles into an operation with different operands -> ignored; first result returned at cycle 8.
  - start held high during done -> new operation accepted that cycle.
- Reset mid-operation: assert rst at cycle 4 of CALC -> busy/done/result/flags 0 immediately; no done pulse; next start completes normally.
- WIDTH=16, CHUNK=8, sub=1, a=0x8000, b=0x0001 -> done 2 cycles after start; result=0x7FFF, c_out=1, overflow=1.
